// File: rtl/uart_pkg.sv
// Shared types and constants for the lab5 UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = DATA_BITS + 2;
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Free-running modulo-ROLLOVER counter producing a terminal-count strobe.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned ROLLOVER     = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic count_enable,
  output logic rollover_c
);

  localparam logic [NUM_CNT_BITS-1:0] LAST = NUM_CNT_BITS'(ROLLOVER - 1);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  // Terminal count is the last cycle of a period while counting.
  assign rollover_c = count_enable && (count_q == LAST);

  // Next count: clear wins, wrap on terminal count, otherwise increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (rollover_c) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = count_q + NUM_CNT_BITS'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);

  tx_state_t              state_q;
  tx_state_t              state_d;
  logic [FRAME_BITS-1:0]  frame_q;
  logic [FRAME_BITS-1:0]  frame_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_d;
  logic                   busy_q;
  logic                   busy_d;
  logic                   done_q;
  logic                   done_d;
  logic                   serial_q;
  logic                   serial_d;
  logic                   accept;
  logic                   bit_tick;

  assign accept = (state_q == IDLE) && tx_start;

  // Bit-period timer: restarts on accept, runs for the whole frame.
  flex_counter #(
    .NUM_CNT_BITS (CNT_W),
    .ROLLOVER     (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (accept),
    .count_enable (busy_q),
    .rollover_c   (bit_tick)
  );

  // Next state, frame shifting, bit counting and status flags.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          frame_d   = {STOP_BIT, tx_data, START_BIT};
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          frame_d   = {IDLE_LEVEL, frame_q[FRAME_BITS-1:1]};
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          frame_d = {IDLE_LEVEL, frame_q[FRAME_BITS-1:1]};
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          frame_d = {IDLE_LEVEL, frame_q[FRAME_BITS-1:1]};
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Line follows the frame LSB, which is the idle level outside a frame.
    serial_d = frame_d[0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_q   <= '1;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      serial_q  <= IDLE_LEVEL;
    end else begin
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      serial_q  <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
